// File: rtl/tsbus_pkg.sv
// Shared types and helpers for the tristate-bus arbiter: FSM states, requester
// count and one-hot/index conversions matching the 2-to-4 select decoder.
package tsbus_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/tsbus_arbiter_if.sv
// Request/enable bundle between the four bus drivers and the arbiter.
interface tsbus_arbiter_if;
  import tsbus_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] sel;
  logic             bus_busy;
  logic             hold_exp;

  modport master (output req, input gnt, input sel, input bus_busy, input hold_exp);
  modport slave  (input req, output gnt, output sel, output bus_busy, output hold_exp);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr+1, wrapping.
module rr_pick
  import tsbus_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    for (int off = NREQ; off >= 1; off--) begin
      if (req[ptr + IDX_W'(off)]) begin
        valid = 1'b1;
        idx   = ptr + IDX_W'(off);
      end
    end
  end

endmodule

// File: rtl/tsbus_arbiter.sv
// Round-robin owner sequencer for a four-driver tristate line: one-hot enables,
// per-grant hold limit and an all-off turnaround gap between owners.
module tsbus_arbiter
  import tsbus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tsbus_arbiter_if.slave   bus
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [3:0] TURN_LIM = 4'(TURN_CYC);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       turn_q, turn_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             hexp_q, hexp_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             arb_now;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    hexp_d  = 1'b0;
    arb_now = 1'b0;

    case (state_q)
      IDLE: arb_now = 1'b1;
      GRANT: begin
        // sel_q holds the current owner throughout the grant.
        if (!bus.req[sel_q] || (hold_q >= HOLD_LIM)) begin
          state_d = TURN;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q;
          turn_d  = 4'd1;
          hold_d  = 8'd0;
          hexp_d  = bus.req[sel_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q >= TURN_LIM) begin
          arb_now = 1'b1;
          turn_d  = 4'd0;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_now) begin
      if (pick_vld) begin
        state_d = GRANT;
        gnt_d   = idx2onehot(pick_idx);
        sel_d   = pick_idx;
        busy_d  = 1'b1;
        hold_d  = 8'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      turn_q  <= 4'd0;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      hexp_q  <= hexp_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.bus_busy = busy_q;
  assign bus.hold_exp = hexp_q;

endmodule

// File: tb/tb_tsbus_arbiter.sv
// Directed bench for tsbus_arbiter: two instances (hold 8/turn 1 and hold 4/turn 2)
// plus a random-request invariant sweep on the first.
module tb_tsbus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tsbus_arbiter_if bus_a ();
  tsbus_arbiter_if bus_b ();

  tsbus_arbiter #(.MAX_HOLD(8), .TURN_CYC(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  tsbus_arbiter #(.MAX_HOLD(4), .TURN_CYC(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    tick();
    tick();
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus_a.gnt); end
    checks++; if (bus_a.sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", bus_a.sel); end
    checks++; if (bus_a.bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_a.bus_busy); end
    checks++; if (bus_a.hold_exp !== 1'b0) begin errors++; $display("FAIL reset_hexp got %b exp 0", bus_a.hold_exp); end
    checks++; if (bus_b.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt_b got %b exp 0000", bus_b.gnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    bus_a.req = 4'b0001;
    tick();
    checks++; if (bus_a.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", bus_a.gnt); end
    checks++; if (bus_a.sel !== 2'b00) begin errors++; $display("FAIL single_sel got %b exp 00", bus_a.sel); end
    checks++; if (bus_a.bus_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus_a.bus_busy); end
    repeat (3) tick();
    checks++; if (bus_a.gnt !== 4'b0001) begin errors++; $display("FAIL single_keep got %b exp 0001", bus_a.gnt); end
    bus_a.req = 4'b0000;
    tick();
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("FAIL single_drop_gnt got %b exp 0000", bus_a.gnt); end
    checks++; if (bus_a.bus_busy !== 1'b0) begin errors++; $display("FAIL single_drop_busy got %b exp 0", bus_a.bus_busy); end
    checks++; if (bus_a.sel !== 2'b00) begin errors++; $display("FAIL single_drop_sel got %b exp 00", bus_a.sel); end
    checks++; if (bus_a.hold_exp !== 1'b0) begin errors++; $display("FAIL single_drop_hexp got %b exp 0", bus_a.hold_exp); end
    tick();
    bus_a.req = 4'b0010;
    tick();
    checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL idle_regrant got %b exp 0010", bus_a.gnt); end
    checks++; if (bus_a.sel !== 2'b01) begin errors++; $display("FAIL idle_regrant_sel got %b exp 01", bus_a.sel); end
    bus_a.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    rst_n = 1'b0;
    bus_a.req = 4'b0000;
    tick();
    rst_n = 1'b1;
    bus_a.req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++) begin
        checks++; if (bus_a.gnt !== exp_oh) begin errors++; $display("FAIL rr_gnt g%0d c%0d got %b exp %b", g, c, bus_a.gnt, exp_oh); end
        checks++; if (bus_a.hold_exp !== 1'b0) begin errors++; $display("FAIL rr_hexp_low g%0d c%0d got %b exp 0", g, c, bus_a.hold_exp); end
        tick();
      end
      checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap g%0d got %b exp 0000", g, bus_a.gnt); end
      checks++; if (bus_a.hold_exp !== 1'b1) begin errors++; $display("FAIL rr_hexp g%0d got %b exp 1", g, bus_a.hold_exp); end
      checks++; if (bus_a.sel !== 2'(g % 4)) begin errors++; $display("FAIL rr_sel g%0d got %0d exp %0d", g, bus_a.sel, g % 4); end
      tick();
    end
    bus_a.req = 4'b0000;
    tick();
    checks++; if (bus_a.hold_exp !== 1'b0) begin errors++; $display("FAIL rr_voluntary_hexp got %b exp 0", bus_a.hold_exp); end
    tick();
    tick();
  endtask

  task automatic test_hold_alone;
    bus_b.req = 4'b0100;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (bus_b.gnt !== 4'b0100) begin errors++; $display("FAIL hold_gnt r%0d c%0d got %b exp 0100", r, c, bus_b.gnt); end
        tick();
      end
      checks++; if (bus_b.gnt !== 4'b0000) begin errors++; $display("FAIL hold_turn1 r%0d got %b exp 0000", r, bus_b.gnt); end
      checks++; if (bus_b.hold_exp !== 1'b1) begin errors++; $display("FAIL hold_hexp r%0d got %b exp 1", r, bus_b.hold_exp); end
      tick();
      checks++; if (bus_b.gnt !== 4'b0000) begin errors++; $display("FAIL hold_turn2 r%0d got %b exp 0000", r, bus_b.gnt); end
      checks++; if (bus_b.hold_exp !== 1'b0) begin errors++; $display("FAIL hold_hexp_pulse r%0d got %b exp 0", r, bus_b.hold_exp); end
      tick();
    end
    checks++; if (bus_b.gnt !== 4'b0100) begin errors++; $display("FAIL hold_third got %b exp 0100", bus_b.gnt); end
    bus_b.req = 4'b0000;
    tick();
    checks++; if (bus_b.gnt !== 4'b0000) begin errors++; $display("FAIL hold_drop got %b exp 0000", bus_b.gnt); end
    checks++; if (bus_b.hold_exp !== 1'b0) begin errors++; $display("FAIL hold_drop_hexp got %b exp 0", bus_b.hold_exp); end
    repeat (3) tick();
  endtask

  task automatic test_handover;
    bus_a.req = 4'b0010;
    tick();
    checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL ho_first got %b exp 0010", bus_a.gnt); end
    tick();
    bus_a.req = 4'b1010;
    tick();
    checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL ho_keep got %b exp 0010", bus_a.gnt); end
    bus_a.req = 4'b1000;
    tick();
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("FAIL ho_gap got %b exp 0000", bus_a.gnt); end
    checks++; if (bus_a.hold_exp !== 1'b0) begin errors++; $display("FAIL ho_hexp got %b exp 0", bus_a.hold_exp); end
    tick();
    checks++; if (bus_a.gnt !== 4'b1000) begin errors++; $display("FAIL ho_next got %b exp 1000", bus_a.gnt); end
    checks++; if (bus_a.sel !== 2'b11) begin errors++; $display("FAIL ho_next_sel got %b exp 11", bus_a.sel); end
    bus_a.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    bus_a.req = 4'b0100;
    tick();
    bus_a.req = 4'b0000;
    tick();
    tick();
    bus_a.req = 4'b0010;
    tick();
    checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL rm_pre got %b exp 0010", bus_a.gnt); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("FAIL rm_gnt got %b exp 0000", bus_a.gnt); end
    checks++; if (bus_a.sel !== 2'b00) begin errors++; $display("FAIL rm_sel got %b exp 00", bus_a.sel); end
    checks++; if (bus_a.bus_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus_a.bus_busy); end
    rst_n = 1'b1;
    bus_a.req = 4'b1110;
    tick();
    checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL rm_after got %b exp 0010", bus_a.gnt); end
    checks++; if (bus_a.sel !== 2'b01) begin errors++; $display("FAIL rm_after_sel got %b exp 01", bus_a.sel); end
    bus_a.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random;
    logic [3:0] r_s, g, prev;
    int wcnt [4];
    int run;
    bit newg;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    run = 0;
    prev = bus_a.gnt;
    bus_a.req = 4'($urandom_range(15));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_s = bus_a.req;
      tick();
      g = bus_a.gnt;
      checks++; if ($countones(g) > 1) begin errors++; $display("FAIL rnd_onehot cyc%0d got %b exp one-hot or 0000", cyc, g); end
      checks++; if (prev != 4'b0000 && g != 4'b0000 && g != prev) begin errors++; $display("FAIL rnd_overlap cyc%0d got %b after %b exp gap", cyc, g, prev); end
      if (g != 4'b0000 && g == prev) run++;
      else if (g != 4'b0000) run = 1;
      else run = 0;
      checks++; if (run > 8) begin errors++; $display("FAIL rnd_hold cyc%0d got %0d cycles exp <=8", cyc, run); end
      newg = (g != 4'b0000) && (prev == 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (!r_s[i]) wcnt[i] = 0;
        else if (newg) begin
          if (g[i]) wcnt[i] = 0;
          else wcnt[i]++;
        end
        checks++; if (wcnt[i] > 3) begin errors++; $display("FAIL rnd_starve cyc%0d req%0d got %0d grants exp <=3", cyc, i, wcnt[i]); end
      end
      prev = g;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) bus_a.req[i] = ~bus_a.req[i];
      end
    end
    bus_a.req = 4'b0000;
    repeat (3) tick();
  endtask

  initial begin
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_alone();
    test_handover();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
